// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// cpu_control_fsm : instruction register, decoder and Moore sequencer for the
//                   simple RISC CPU (datapath, memory and PC strobes).
// Revision 1.0
// ============================================================================
module cpu_control_fsm (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] read_data,
  output logic [1:0]  vsel,
  output logic [2:0]  writenum,
  output logic [2:0]  readnum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] sximm5,
  output logic [15:0] sximm8,
  output logic [1:0]  mem_cmd,
  output logic        addr_sel,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        load_addr,
  output logic        halted
);

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;

  localparam logic [1:0] VSEL_DP   = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;
  localparam logic [1:0] VSEL_MEM  = 2'b11;

  typedef enum logic [4:0] {
    S_RST       = 5'd0,
    S_IF1       = 5'd1,
    S_IF2       = 5'd2,
    S_UPDATE_PC = 5'd3,
    S_DECODE    = 5'd4,
    S_WRITE_IMM = 5'd5,
    S_GET_A     = 5'd6,
    S_GET_B     = 5'd7,
    S_ALU       = 5'd8,
    S_WRITE_REG = 5'd9,
    S_ADDR      = 5'd10,
    S_LOAD_ADDR = 5'd11,
    S_MEM_RD    = 5'd12,
    S_WB_MEM    = 5'd13,
    S_GET_D     = 5'd14,
    S_PASS_D    = 5'd15,
    S_MEM_WR    = 5'd16,
    S_HALT      = 5'd17
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [15:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn;
  logic [2:0] rd;
  logic [1:0] sh;
  logic [2:0] rm;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};

  logic is_movi;
  logic is_movr;
  logic is_mvn;
  logic is_add;
  logic is_and;
  logic is_cmp;
  logic is_ldr;
  logic is_str;
  logic is_halt;
  logic is_mem;
  logic mem_seq;

  assign is_movi = (opcode == 3'b110) && (op == 2'b10);
  assign is_movr = (opcode == 3'b110) && (op == 2'b00);
  assign is_mvn  = (opcode == 3'b101) && (op == 2'b11);
  assign is_add  = (opcode == 3'b101) && (op == 2'b00);
  assign is_and  = (opcode == 3'b101) && (op == 2'b10);
  assign is_cmp  = (opcode == 3'b101) && (op == 2'b01);
  assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
  assign is_str  = (opcode == 3'b100) && (op == 2'b00);
  assign is_halt = (opcode == 3'b111);
  assign is_mem  = is_ldr || is_str;

  // The address-arithmetic states of LDR/STR always use an unshifted operand.
  assign mem_seq = ((state == S_GET_A) && is_mem) ||
                   (state == S_ADDR)   || (state == S_LOAD_ADDR) ||
                   (state == S_MEM_RD) || (state == S_WB_MEM)    ||
                   (state == S_GET_D)  || (state == S_PASS_D)    ||
                   (state == S_MEM_WR);

  assign shift = mem_seq ? 2'b00 : sh;
  assign ALUop = (opcode == 3'b101) ? op : 2'b00;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RST;
      ir    <= 16'h0000;
    end else begin
      state <= next_state;
      if (state == S_IF2) begin
        ir <= read_data;
      end
    end
  end

  always_comb begin
    next_state = state;
    vsel       = VSEL_DP;
    writenum   = 3'd0;
    readnum    = 3'd0;
    write      = 1'b0;
    loada      = 1'b0;
    loadb      = 1'b0;
    loadc      = 1'b0;
    loads      = 1'b0;
    asel       = 1'b0;
    bsel       = 1'b0;
    mem_cmd    = MEM_NONE;
    addr_sel   = 1'b0;
    load_pc    = 1'b0;
    reset_pc   = 1'b0;
    load_addr  = 1'b0;
    halted     = 1'b0;

    case (state)
      S_RST: begin
        reset_pc   = 1'b1;
        load_pc    = 1'b1;
        next_state = S_IF1;
      end
      S_IF1: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        next_state = S_IF2;
      end
      S_IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        next_state = S_UPDATE_PC;
      end
      S_UPDATE_PC: begin
        load_pc    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        if (is_movi) begin
          next_state = S_WRITE_IMM;
        end else if (is_movr || is_mvn) begin
          next_state = S_GET_B;
        end else if (is_add || is_and || is_cmp || is_mem) begin
          next_state = S_GET_A;
        end else if (is_halt) begin
          next_state = S_HALT;
        end else begin
          next_state = S_IF1;
        end
      end
      S_WRITE_IMM: begin
        vsel       = VSEL_IMM8;
        writenum   = rn;
        write      = 1'b1;
        next_state = S_IF1;
      end
      S_GET_A: begin
        readnum    = rn;
        loada      = 1'b1;
        next_state = is_mem ? S_ADDR : S_GET_B;
      end
      S_GET_B: begin
        readnum    = rm;
        loadb      = 1'b1;
        next_state = S_ALU;
      end
      S_ALU: begin
        // Single-operand moves force the A input to zero.
        asel       = is_movr || is_mvn;
        loadc      = !is_cmp;
        loads      = is_cmp;
        next_state = is_cmp ? S_IF1 : S_WRITE_REG;
      end
      S_WRITE_REG: begin
        vsel       = VSEL_DP;
        writenum   = rd;
        write      = 1'b1;
        next_state = S_IF1;
      end
      S_ADDR: begin
        bsel       = 1'b1;
        loadc      = 1'b1;
        next_state = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        load_addr  = 1'b1;
        next_state = is_str ? S_GET_D : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_cmd    = MEM_READ;
        next_state = S_WB_MEM;
      end
      S_WB_MEM: begin
        mem_cmd    = MEM_READ;
        vsel       = VSEL_MEM;
        writenum   = rd;
        write      = 1'b1;
        next_state = S_IF1;
      end
      S_GET_D: begin
        readnum    = rd;
        loadb      = 1'b1;
        next_state = S_PASS_D;
      end
      S_PASS_D: begin
        asel       = 1'b1;
        loadc      = 1'b1;
        next_state = S_MEM_WR;
      end
      S_MEM_WR: begin
        mem_cmd    = MEM_WRITE;
        next_state = S_IF1;
      end
      S_HALT: begin
        halted     = 1'b1;
        next_state = S_HALT;
      end
      default: begin
        next_state = S_RST;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu_control_fsm.sv
`default_nettype none
// ============================================================================
// tb_cpu_control_fsm : directed + random instruction sequences checked cycle by
//                      cycle against a phase-list reference model.
// Revision 1.0
// ============================================================================
module tb_cpu_control_fsm;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] read_data = 16'h0000;

  logic [1:0]  vsel;
  logic [2:0]  writenum, readnum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm5, sximm8;
  logic [1:0]  mem_cmd;
  logic        addr_sel, load_pc, reset_pc, load_addr, halted;

  cpu_control_fsm dut (
    .clk(clk), .reset_n(reset_n), .read_data(read_data),
    .vsel(vsel), .writenum(writenum), .readnum(readnum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc),
    .loads(loads), .asel(asel), .bsel(bsel), .shift(shift),
    .ALUop(ALUop), .sximm5(sximm5), .sximm8(sximm8),
    .mem_cmd(mem_cmd), .addr_sel(addr_sel), .load_pc(load_pc),
    .reset_pc(reset_pc), .load_addr(load_addr), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  vsel;
    logic [2:0]  writenum;
    logic [2:0]  readnum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  shift;
    logic [1:0]  aluop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;
    logic [1:0]  mem_cmd;
    logic        addr_sel, load_pc, reset_pc, load_addr, halted;
  } ctl_t;

  ctl_t obs;
  always_comb obs = {vsel, writenum, readnum, write, loada, loadb, loadc,
                     loads, asel, bsel, shift, ALUop, sximm5, sximm8,
                     mem_cmd, addr_sel, load_pc, reset_pc, load_addr, halted};

  localparam int P_RST = 0, P_IF1 = 1, P_IF2 = 2, P_UPD = 3, P_DEC = 4,
                 P_WIMM = 5, P_GA = 6, P_GB = 7, P_ALU = 8, P_WREG = 9,
                 P_ADDR = 10, P_LADDR = 11, P_MRD = 12, P_WBM = 13,
                 P_GD = 14, P_PASS = 15, P_MWR = 16, P_HALT = 17;

  localparam int K_MOVI = 0, K_MOVR = 1, K_MVN = 2, K_ADD = 3, K_AND = 4,
                 K_CMP = 5, K_LDR = 6, K_STR = 7, K_HALT = 8, K_NOP = 9;

  int errors = 0;
  int checks = 0;
  logic [15:0] model_ir = 16'h0000;
  int ph_q[$];
  bit ls_q[$];

  function automatic int classify(logic [15:0] ir);
    logic [4:0] oo;
    oo = ir[15:11];
    if (ir[15:13] == 3'b111) return K_HALT;
    case (oo)
      5'b11010: return K_MOVI;
      5'b11000: return K_MOVR;
      5'b10111: return K_MVN;
      5'b10100: return K_ADD;
      5'b10110: return K_AND;
      5'b10101: return K_CMP;
      5'b01100: return K_LDR;
      5'b10000: return K_STR;
      default:  return K_NOP;
    endcase
  endfunction

  function automatic logic [15:0] sext(int v, int bits);
    int s;
    s = v;
    if (s >= (1 << (bits - 1))) s = s - (1 << bits);
    return 16'(s);
  endfunction

  // Expected outputs for one phase of an instruction whose IR is 'ir'.
  function automatic ctl_t model(int ph, logic [15:0] ir, bit ls);
    ctl_t c;
    int   k;
    c = '0;
    k = classify(ir);
    c.shift  = ls ? 2'b00 : ir[4:3];
    c.aluop  = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
    c.sximm5 = sext(int'(ir[4:0]), 5);
    c.sximm8 = sext(int'(ir[7:0]), 8);
    case (ph)
      P_RST:   begin c.reset_pc = 1; c.load_pc = 1; end
      P_IF1,
      P_IF2:   begin c.addr_sel = 1; c.mem_cmd = 2'b01; end
      P_UPD:   c.load_pc = 1;
      P_WIMM:  begin c.vsel = 2'b10; c.writenum = ir[10:8]; c.write = 1; end
      P_GA:    begin c.readnum = ir[10:8]; c.loada = 1; end
      P_GB:    begin c.readnum = ir[2:0]; c.loadb = 1; end
      P_ALU:   begin
                 c.asel  = (k == K_MOVR) || (k == K_MVN);
                 c.loadc = (k != K_CMP);
                 c.loads = (k == K_CMP);
               end
      P_WREG:  begin c.writenum = ir[7:5]; c.write = 1; end
      P_ADDR:  begin c.bsel = 1; c.loadc = 1; end
      P_LADDR: c.load_addr = 1;
      P_MRD:   c.mem_cmd = 2'b01;
      P_WBM:   begin c.mem_cmd = 2'b01; c.vsel = 2'b11; c.writenum = ir[7:5]; c.write = 1; end
      P_GD:    begin c.readnum = ir[7:5]; c.loadb = 1; end
      P_PASS:  begin c.asel = 1; c.loadc = 1; end
      P_MWR:   c.mem_cmd = 2'b10;
      P_HALT:  c.halted = 1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic push(int ph, bit ls);
    ph_q.push_back(ph);
    ls_q.push_back(ls);
  endtask

  task automatic build_seq(int k, int halt_cycles);
    ph_q.delete();
    ls_q.delete();
    push(P_IF1, 0); push(P_IF2, 0); push(P_UPD, 0); push(P_DEC, 0);
    case (k)
      K_MOVI: push(P_WIMM, 0);
      K_MOVR, K_MVN: begin push(P_GB, 0); push(P_ALU, 0); push(P_WREG, 0); end
      K_ADD, K_AND: begin
        push(P_GA, 0); push(P_GB, 0); push(P_ALU, 0); push(P_WREG, 0);
      end
      K_CMP: begin push(P_GA, 0); push(P_GB, 0); push(P_ALU, 0); end
      K_LDR: begin
        push(P_GA, 1); push(P_ADDR, 1); push(P_LADDR, 1); push(P_MRD, 1); push(P_WBM, 1);
      end
      K_STR: begin
        push(P_GA, 1); push(P_ADDR, 1); push(P_LADDR, 1);
        push(P_GD, 1); push(P_PASS, 1); push(P_MWR, 1);
      end
      K_HALT: for (int i = 0; i < halt_cycles; i++) push(P_HALT, 0);
      default: ;
    endcase
  endtask

  task automatic check(string tag, ctl_t e);
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // Runs an instruction from its IF1; returns 1 ns after the edge that ends
  // the last phase run (IF1 of the next instruction when fully executed).
  task automatic run_instr(string label, logic [15:0] ir, int max_ph = 1000);
    logic [15:0] old_ir;
    old_ir = model_ir;
    build_seq(classify(ir), 25);
    for (int i = 0; i < ph_q.size() && i < max_ph; i++) begin
      read_data = (ph_q[i] == P_IF2) ? ir : 16'($urandom);
      @(negedge clk);
      if (ph_q[i] == P_IF1 || ph_q[i] == P_IF2)
        check($sformatf("%s/ph%0d", label, ph_q[i]), model(ph_q[i], old_ir, ls_q[i]));
      else
        check($sformatf("%s/ph%0d", label, ph_q[i]), model(ph_q[i], ir, ls_q[i]));
      @(posedge clk);
      #1;
      if (ph_q[i] == P_IF2) model_ir = ir;
    end
  endtask

  task automatic async_reset(string label);
    #2;
    reset_n = 1'b0;
    model_ir = 16'h0000;
    #1;
    check({label, "/immediate"}, model(P_RST, model_ir, 0));
    @(negedge clk);
    check({label, "/held"}, model(P_RST, model_ir, 0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [4:0] valid_oo [8];

  initial begin
    logic [15:0] r;
    valid_oo[0] = 5'b11010; valid_oo[1] = 5'b11000; valid_oo[2] = 5'b10111;
    valid_oo[3] = 5'b10100; valid_oo[4] = 5'b10110; valid_oo[5] = 5'b10101;
    valid_oo[6] = 5'b01100; valid_oo[7] = 5'b10000;

    #2;
    check("por/immediate", model(P_RST, 16'h0000, 0));
    @(negedge clk);
    check("por/held", model(P_RST, 16'h0000, 0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    run_instr("movimm", 16'hD0FD);
    run_instr("add_cut", 16'hA148, 7);
    check("add_cut/wreg", model(P_WREG, 16'hA148, 0));
    async_reset("midadd");

    run_instr("add", 16'hA148);
    run_instr("cmp", 16'hA900);
    run_instr("ldr", 16'h617F);
    run_instr("str", 16'h8162);

    for (int n = 0; n < 80; n++) begin
      r = 16'($urandom);
      if (n % 2 == 0) r[15:11] = valid_oo[$urandom_range(0, 7)];
      if (r[15:13] == 3'b111) r[14] = 1'b0;
      run_instr($sformatf("rnd%0d", n), r);
    end

    run_instr("halt", 16'hE000);
    async_reset("halt_rst");
    run_instr("nop", 16'h2000);
    run_instr("after_nop", 16'hD7AA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
